// File: rtl/fcn_layer_ctrl_pkg.sv
// fcn_layer_ctrl_pkg: shared FCN default widths and layer-controller state encoding
package fcn_layer_ctrl_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_LEN_W = 10;
  localparam int DEF_GRP_W = 6;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_CLR = 3'd1;
  localparam state_t S_ACC = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_STORE = 3'd4;
  localparam state_t S_DONE = 3'd5;
endpackage

// File: rtl/fcn_layer_ctrl.sv
// fcn_layer_ctrl: sequences buffer reads, PE clear/accumulate and result hand-off for one FC layer
module fcn_layer_ctrl
  import fcn_layer_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int GRP_W = DEF_GRP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_in_len,
  input  logic [GRP_W-1:0]  cfg_groups,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [LEN_W-1:0]  in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              pe_clr,
  output logic              pe_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [GRP_W-1:0]  out_grp
);
  state_t state;
  logic [LEN_W-1:0] k, in_len;
  logic [GRP_W-1:0] grp, groups;
  logic [ADDR_W-1:0] group_base;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign rd_en = state == S_ACC && !hold;
  assign pe_clr = state == S_CLR;
  assign out_valid = state == S_STORE;
  assign out_grp = grp;
  assign in_addr = k;
  assign w_addr = group_base + ADDR_W'(k);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      k <= '0;
      in_len <= '0;
      groups <= '0;
      grp <= '0;
      group_base <= '0;
      pe_ready <= 1'b0;
    end else begin
      pe_ready <= rd_en;
      case (state)
        S_IDLE: if (start) begin
          if (cfg_in_len != '0 && cfg_groups != '0) begin
            in_len <= cfg_in_len;
            groups <= cfg_groups;
            grp <= '0;
            group_base <= '0;
            state <= S_CLR;
          end else state <= S_DONE;
        end
        S_CLR: begin
          k <= '0;
          state <= S_ACC;
        end
        S_ACC: if (!hold) begin
          k <= k + LEN_W'(1);
          if (k == in_len - LEN_W'(1)) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_STORE;
        S_STORE: if (out_ready) begin
          if (grp == groups - GRP_W'(1)) state <= S_DONE;
          else begin
            // next group's weights start right after this group's in_len weights
            grp <= grp + GRP_W'(1);
            group_base <= group_base + ADDR_W'(in_len);
            state <= S_CLR;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
